// File: rtl/dm_dump_arbiter.sv
// Data-memory port arbiter between the pipeline MEM stage and a read-only dump engine.
// The CPU passes through combinationally in IDLE. A dump edge walks all DEPTH words out on a valid/ready stream.
module dm_dump_arbiter #(
   parameter int N     = 64,
   parameter int DEPTH = 64
) (
   input  logic         CLOCK_50,
   input  logic         reset,
   input  logic         cpu_req,
   input  logic         cpu_we,
   input  logic [N-1:0] cpu_addr,
   input  logic [N-1:0] cpu_wdata,
   output logic [N-1:0] cpu_rdata,
   output logic         cpu_stall,
   output logic [N-1:0] mem_addr,
   output logic         mem_we,
   output logic [N-1:0] mem_wdata,
   input  logic [N-1:0] mem_rdata,
   input  logic         dump,
   output logic         dump_valid,
   input  logic         dump_ready,
   output logic [N-1:0] dump_addr,
   output logic [N-1:0] dump_data,
   output logic         dump_busy,
   output logic         dump_done
);

   localparam int           IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
   localparam logic [N-1:0] WORD_BYTES = N'(N / 8);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DUMP = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_r;
   logic [IW-1:0] idx_r;
   logic          dump_q_r;
   logic          valid_r;
   logic          busy_r;
   logic          done_r;

   logic [N-1:0]  dump_addr_s;
   logic [N-1:0]  dump_data_s;
   logic [N-1:0]  mem_addr_s;
   logic [N-1:0]  mem_wdata_s;
   logic          mem_we_s;
   logic          cpu_stall_s;

   // dump_q resets high so a dump held through reset is not seen as a new edge.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_r  <= IDLE;
         idx_r    <= '0;
         dump_q_r <= 1'b1;
         valid_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         dump_q_r <= dump;
         case (state_r)
            IDLE: begin
               if (dump && !dump_q_r) begin
                  state_r <= DUMP;
                  idx_r   <= '0;
                  valid_r <= 1'b1;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            DUMP: begin
               if (dump_ready) begin
                  if (idx_r == LAST_IDX) begin
                     state_r <= DONE;
                     idx_r   <= '0;
                     valid_r <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     idx_r <= idx_r + 1'b1;
                  end
               end else begin
                  idx_r <= idx_r;
               end
            end
            DONE: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               idx_r   <= '0;
               valid_r <= 1'b0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign dump_addr_s = {{(N-IW){1'b0}}, idx_r} * WORD_BYTES;
   assign dump_data_s = (state_r == DUMP) ? mem_rdata : '0;

   // Memory port mux; mem_we is gated by reset so nothing is written while reset is held.
   always_comb begin
      mem_addr_s  = cpu_addr;
      mem_wdata_s = cpu_wdata;
      mem_we_s    = reset & cpu_req & cpu_we;
      cpu_stall_s = 1'b0;
      case (state_r)
         IDLE: begin
            mem_addr_s  = cpu_addr;
            mem_wdata_s = cpu_wdata;
            mem_we_s    = reset & cpu_req & cpu_we;
            cpu_stall_s = 1'b0;
         end
         DUMP, DONE: begin
            mem_addr_s  = dump_addr_s;
            mem_wdata_s = '0;
            mem_we_s    = 1'b0;
            cpu_stall_s = cpu_req;
         end
         default: begin
            mem_addr_s  = dump_addr_s;
            mem_wdata_s = '0;
            mem_we_s    = 1'b0;
            cpu_stall_s = cpu_req;
         end
      endcase
   end

   assign cpu_rdata  = mem_rdata;
   assign cpu_stall  = cpu_stall_s;
   assign mem_addr   = mem_addr_s;
   assign mem_we     = mem_we_s;
   assign mem_wdata  = mem_wdata_s;
   assign dump_valid = valid_r;
   assign dump_addr  = dump_addr_s;
   assign dump_data  = dump_data_s;
   assign dump_busy  = busy_r;
   assign dump_done  = done_r;

endmodule

// File: tb/tb_dm_dump_arbiter.sv
// Self-checking bench for dm_dump_arbiter: a 4-word memory, a transaction-level model
// of the arbiter checked every cycle, and literal expectations from the test plan.
module tb_dm_dump_arbiter;

   localparam int N     = 64;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset;
   logic          cpu_req;
   logic          cpu_we;
   logic [N-1:0]  cpu_addr;
   logic [N-1:0]  cpu_wdata;
   logic [N-1:0]  cpu_rdata;
   logic          cpu_stall;
   logic [N-1:0]  mem_addr;
   logic          mem_we;
   logic [N-1:0]  mem_wdata;
   logic [N-1:0]  mem_rdata;
   logic          dump;
   logic          dump_valid;
   logic          dump_ready;
   logic [N-1:0]  dump_addr;
   logic [N-1:0]  dump_data;
   logic          dump_busy;
   logic          dump_done;

   int checks;
   int errors;

   dm_dump_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .dump       (dump),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_busy  (dump_busy),
      .dump_done  (dump_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment memory: combinational read, write on the rising edge.
   logic [N-1:0] ram [DEPTH];
   assign mem_rdata = ram[mem_addr[4:3]];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr[4:3]] <= mem_wdata;
   end

   // Reference model: word = -1 idle, 0..DEPTH-1 word being offered, DEPTH = done cycle.
   int           word;
   bit           prev_dump;
   logic [N-1:0] shadow [DEPTH];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         word      = -1;
         prev_dump = 1'b1;
      end else begin
         if (word < 0) begin
            if (cpu_req && cpu_we) shadow[cpu_addr[4:3]] = cpu_wdata;
            if (dump && !prev_dump) word = 0;
         end else if (word < DEPTH) begin
            if (dump_ready) word = word + 1;
         end else begin
            word = -1;
         end
         prev_dump = dump;
      end
   end

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("cpu_rdata", cpu_rdata, mem_rdata);
      if (word < 0) begin
         chk("idle mem_addr", mem_addr, cpu_addr);
         chk("idle mem_wdata", mem_wdata, cpu_wdata);
         chk("idle mem_we", N'(mem_we), N'(reset & cpu_req & cpu_we));
         chk("idle cpu_stall", N'(cpu_stall), '0);
         chk("idle dump_valid", N'(dump_valid), '0);
         chk("idle dump_busy", N'(dump_busy), '0);
         chk("idle dump_done", N'(dump_done), '0);
      end else if (word < DEPTH) begin
         chk("dump mem_addr", mem_addr, N'(word * 8));
         chk("dump mem_we", N'(mem_we), '0);
         chk("dump mem_wdata", mem_wdata, '0);
         chk("dump cpu_stall", N'(cpu_stall), N'(cpu_req));
         chk("dump dump_valid", N'(dump_valid), N'(1));
         chk("dump dump_busy", N'(dump_busy), N'(1));
         chk("dump dump_done", N'(dump_done), '0);
         chk("dump dump_addr", dump_addr, N'(word * 8));
         chk("dump dump_data", dump_data, shadow[word]);
      end else begin
         chk("done mem_we", N'(mem_we), '0);
         chk("done cpu_stall", N'(cpu_stall), N'(cpu_req));
         chk("done dump_valid", N'(dump_valid), '0);
         chk("done dump_busy", N'(dump_busy), N'(1));
         chk("done dump_done", N'(dump_done), N'(1));
      end
   endtask

   task automatic settle();
      @(negedge clk);
      compare_model();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         settle();
         adv();
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b0;
      dump       = 1'b0;
      dump_ready = 1'b1;
      cpu_req    = 1'b0;
      cpu_we     = 1'b0;
      cpu_addr   = '0;
      cpu_wdata  = '0;
      #2;
      settle();
      chk("reset dump_valid", N'(dump_valid), '0);
      chk("reset dump_busy", N'(dump_busy), '0);
      chk("reset cpu_stall", N'(cpu_stall), '0);
      adv();
      adv();
      reset = 1'b1;

      // 1: IDLE pass-through write then read back
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h10; cpu_wdata = 64'hA5;
      settle();
      chk("t1 mem_we", N'(mem_we), 64'd1);
      chk("t1 mem_addr", mem_addr, 64'h10);
      chk("t1 mem_wdata", mem_wdata, 64'hA5);
      chk("t1 cpu_stall", N'(cpu_stall), 64'd0);
      adv();
      cpu_we = 1'b0;
      settle();
      chk("t1 cpu_rdata", cpu_rdata, 64'hA5);
      adv();

      // Preload word k = k*0x11 through the CPU path
      for (int k = 0; k < DEPTH; k++) begin
         cpu_req = 1'b1; cpu_we = 1'b1;
         cpu_addr = N'(k * 8); cpu_wdata = N'(k * 17);
         settle();
         adv();
      end
      cpu_req = 1'b0; cpu_we = 1'b0;
      run_cycles(1);

      // 2: full dump with ready held high
      dump = 1'b1;
      settle();
      chk("t2 edge dump_valid", N'(dump_valid), 64'd0);
      adv();
      for (int k = 0; k < DEPTH; k++) begin
         settle();
         chk("t2 dump_valid", N'(dump_valid), 64'd1);
         chk("t2 dump_addr", dump_addr, N'(k * 8));
         chk("t2 dump_data", dump_data, N'(k * 17));
         adv();
      end
      settle();
      chk("t2 dump_done", N'(dump_done), 64'd1);
      adv();
      settle();
      chk("t2 busy after done", N'(dump_busy), 64'd0);
      chk("t2 done pulse width", N'(dump_done), 64'd0);
      adv();
      dump = 1'b0;
      run_cycles(1);

      // 3: backpressure on word 1
      dump = 1'b1;
      run_cycles(2);
      for (int c = 0; c < 4; c++) begin
         dump_ready = (c == 3);
         settle();
         chk("t3 held dump_addr", dump_addr, 64'd8);
         chk("t3 held dump_data", dump_data, 64'h11);
         adv();
      end
      settle();
      chk("t3 next dump_addr", dump_addr, 64'd16);
      chk("t3 next dump_data", dump_data, 64'h22);
      adv();
      run_cycles(2);
      dump = 1'b0;
      run_cycles(1);

      // 4: CPU write held across a dump
      dump = 1'b1;
      settle();
      adv();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h0; cpu_wdata = 64'hFF;
      settle();
      chk("t4 stall", N'(cpu_stall), 64'd1);
      chk("t4 mem_we", N'(mem_we), 64'd0);
      chk("t4 word0", dump_data, 64'h00);
      adv();
      for (int k = 1; k < DEPTH + 1; k++) begin
         settle();
         chk("t4 stall held", N'(cpu_stall), 64'd1);
         chk("t4 mem_we blocked", N'(mem_we), 64'd0);
         adv();
      end
      settle();
      chk("t4 idle stall", N'(cpu_stall), 64'd0);
      chk("t4 idle mem_we", N'(mem_we), 64'd1);
      adv();
      cpu_req = 1'b0; cpu_we = 1'b0; dump = 1'b0;
      run_cycles(1);

      // 5: CPU write in the same cycle as the dump edge
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h0; cpu_wdata = 64'h77; dump = 1'b1;
      settle();
      chk("t5 edge mem_we", N'(mem_we), 64'd1);
      adv();
      cpu_req = 1'b0; cpu_we = 1'b0;
      settle();
      chk("t5 word0 addr", dump_addr, 64'd0);
      chk("t5 word0 data", dump_data, 64'h77);
      adv();
      run_cycles(DEPTH);
      dump = 1'b0;
      run_cycles(1);

      // 6: reset mid-dump while word 2 is valid
      dump = 1'b1;
      run_cycles(3);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h0; cpu_wdata = 64'h77;
      settle();
      chk("t6 word2 addr", dump_addr, 64'd16);
      chk("t6 stall before reset", N'(cpu_stall), 64'd1);
      reset = 1'b0;
      #1;
      compare_model();
      chk("t6 async dump_valid", N'(dump_valid), 64'd0);
      chk("t6 async dump_busy", N'(dump_busy), 64'd0);
      chk("t6 async cpu_stall", N'(cpu_stall), 64'd0);
      chk("t6 async mem_we", N'(mem_we), 64'd0);
      adv();
      cpu_req = 1'b0; cpu_we = 1'b0;
      run_cycles(1);
      reset = 1'b1;
      run_cycles(3);
      chk("t6 no retrigger", N'(dump_busy), 64'd0);
      dump = 1'b0;
      run_cycles(1);
      dump = 1'b1;
      run_cycles(1);
      settle();
      chk("t6 restart valid", N'(dump_valid), 64'd1);
      chk("t6 restart addr", dump_addr, 64'd0);
      adv();
      run_cycles(DEPTH + 1);
      dump = 1'b0;
      run_cycles(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dm_dump_arbiter.md
Name: dm_dump_arbiter

Overview:
- Owns the data-memory port of processor_arm and shares it between the pipeline MEM stage and a memory-dump engine.
- In normal operation the CPU drives data memory combinationally through this block.
- On a rising edge of dump, the block stalls CPU memory requests and walks all DEPTH words. Each word is presented on a valid/ready stream for the bench or debug logic, and a one-cycle done pulse marks the end.

Parameters:
N, 64, data and address width in bits
DEPTH, 64, number of N-bit words in data memory to dump
IW, $clog2(DEPTH), word-index counter width (derived)

Ports:
CLOCK_50  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low (0 = reset)
cpu_req  in  1  MEM stage memory access this cycle
cpu_we  in  1  MEM stage access is a write
cpu_addr  in  N  MEM stage byte address
cpu_wdata  in  N  MEM stage write data
cpu_rdata  out  N  read data to MEM stage
cpu_stall  out  1  stall the pipeline; the access was not performed
mem_addr  out  N  data memory byte address
mem_we  out  1  data memory write enable
mem_wdata  out  N  data memory write data
mem_rdata  in  N  data memory read data (combinational read of mem_addr)
dump  in  1  dump request; rising edge starts a dump
dump_valid  out  1  dump_addr and dump_data are valid
dump_ready  in  1  consumer accepts the current word
dump_addr  out  N  byte address of the current word
dump_data  out  N  contents of the current word
dump_busy  out  1  dump in progress
dump_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- FSM states: IDLE, DUMP, DONE. Registers: state, idx[IW-1:0], dump_q (previous dump).
- Reset (asynchronous, reset=0):
  - state=IDLE, idx=0, dump_q=1.
  - dump_valid=0, dump_busy=0, dump_done=0, cpu_stall=0, mem_we=0.
  - Because dump_q resets to 1, a dump held high through reset does not retrigger.
- cpu_rdata = mem_rdata in all states.
- IDLE (combinational pass-through):
  - mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_req&cpu_we, cpu_stall=0.
  - If dump & ~dump_q: go to DUMP with idx=0.
  - A CPU access in the same cycle as the dump edge completes in that cycle.
- DUMP:
  - mem_addr = dump_addr = idx*(N/8), zero-extended. mem_we=0, mem_wdata=0.
  - dump_valid=1, dump_busy=1, dump_data=mem_rdata.
  - cpu_stall=cpu_req, so CPU writes are blocked and pipeline reads are stalled.
  - On dump_valid & dump_ready: if idx==DEPTH-1, go to DONE and set idx=0; else idx=idx+1.
  - While dump_ready=0, idx, dump_addr and dump_data are held stable.
- DONE (exactly one cycle):
  - dump_done=1, dump_busy=1, dump_valid=0, cpu_stall=cpu_req, mem_we=0.
  - Then go to IDLE.
- dump_q <= dump every cycle, in every state. A dump rising edge outside IDLE is ignored, and deasserting dump mid-dump does not abort it. A new dump needs dump low then high again, with the edge occurring in IDLE.
- A stalled CPU request sees cpu_stall=0 on the first IDLE cycle after DONE, and the access is performed in that cycle.
- Reset mid-dump aborts immediately. The next dump restarts at word 0.
- Read-only dump: memory contents are never modified by the dump engine.
- Latency: a dump edge in cycle t gives word 0 valid in cycle t+1. With dump_ready held 1, the dump takes DEPTH cycles, plus one DONE cycle.
- No address range check on cpu_addr; out-of-range handling belongs to the memory.

Test Plan:
1. Pass-through, IDLE: cpu_req=1, cpu_we=1, cpu_addr=0x10, cpu_wdata=0xA5 -> same cycle mem_we=1, mem_addr=0x10, mem_wdata=0xA5, cpu_stall=0. Then a read of 0x10 returns cpu_rdata=0xA5.
2. Full dump, DEPTH=4, memory preloaded word k = k*0x11, dump_ready=1: raise dump.
   - Expect dump_valid on 4 consecutive cycles with (dump_addr, dump_data) = (0,0x00), (8,0x11), (16,0x22), (24,0x33).
   - Then dump_done=1 for one cycle, then dump_busy=0.
3. Backpressure: dump_ready=0 for 3 cycles while word 1 is presented -> dump_addr=8, dump_data=0x11 held for 4 cycles. Word 2 appears the cycle after ready returns to 1.
4. CPU request during dump: cpu_req=1, cpu_we=1, cpu_addr=0, cpu_wdata=0xFF held throughout.
   - During DUMP/DONE: cpu_stall=1, mem_we=0, and the dumped word 0 equals 0x00.
   - First IDLE cycle: cpu_stall=0 and mem_we=1.
5. Simultaneous events: cpu_req=1, cpu_we=1, cpu_addr=0, cpu_wdata=0x77 in the same cycle as the dump edge -> the write commits that cycle, and dumped word 0 = 0x77.
6. Reset mid-dump: drop reset while word 2 is valid -> dump_valid, dump_busy, cpu_stall and mem_we go 0 asynchronously.
   - dump is held high through reset: no new dump starts.
   - dump low then high: the new dump restarts at dump_addr=0.
